// File: rtl/traffic_lights.sv
// Four-road traffic light controller: round-robin green allocation driven by
// stop-line/queue sensors, with start pulses to an external phase timer.
module traffic_lights (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sensor_1_1,
  input  logic       i_sensor_2_1,
  input  logic       i_sensor_3_1,
  input  logic       i_sensor_4_1,
  input  logic       i_sensor_1_5,
  input  logic       i_sensor_2_5,
  input  logic       i_sensor_3_5,
  input  logic       i_sensor_4_5,
  input  logic       counter_done,
  output logic       short_counter,
  output logic       long_counter,
  output logic [3:0] current_state
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    G1   = 4'd1,
    Y1   = 4'd2,
    G2   = 4'd3,
    Y2   = 4'd4,
    G3   = 4'd5,
    Y3   = 4'd6,
    G4   = 4'd7,
    Y4   = 4'd8
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] last_reg, last_next;
  logic       short_reg, short_next;
  logic       long_reg, long_next;

  logic [3:0] req;
  logic [3:0] heavy;
  logic [3:0] state_minus_one;
  logic [1:0] cur_road;
  logic [1:0] scan_base;
  logic [1:0] scan_idx;
  logic [1:0] pick;
  logic       pick_valid;
  state_t     pick_green;

  // Road indices are 0..3 internally (road N is index N-1).
  assign req   = {i_sensor_4_1 | i_sensor_4_5, i_sensor_3_1 | i_sensor_3_5,
                  i_sensor_2_1 | i_sensor_2_5, i_sensor_1_1 | i_sensor_1_5};
  assign heavy = {i_sensor_4_5, i_sensor_3_5, i_sensor_2_5, i_sensor_1_5};

  // Green code of road i is 2i+1 and yellow is 2i+2, so (code-1)>>1 recovers i.
  assign state_minus_one = state_reg - 4'd1;
  assign cur_road        = state_minus_one[2:1];

  // In a yellow phase the road being served becomes the scan origin.
  assign scan_base  = (state_reg == IDLE) ? last_reg : cur_road;
  assign pick_green = state_t'({1'b0, pick, 1'b1});

  // Cyclic scan: the origin road itself is visited last (k = 4 wraps to it).
  always_comb begin
    pick_valid = 1'b0;
    pick       = scan_base;
    scan_idx   = scan_base;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = scan_base + k[1:0];
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick       = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    short_next = 1'b0;
    long_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = pick_green;
          long_next  = heavy[pick];
          short_next = !heavy[pick];
        end
      end
      G1, G2, G3, G4: begin
        if (counter_done) begin
          state_next = state_t'(state_reg + 4'd1);
          short_next = 1'b1;
        end
      end
      Y1, Y2, Y3, Y4: begin
        if (counter_done) begin
          last_next = cur_road;
          if (pick_valid) begin
            state_next = pick_green;
            long_next  = heavy[pick];
            short_next = !heavy[pick];
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_reg  <= 2'd3;
      short_reg <= 1'b0;
      long_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      short_reg <= short_next;
      long_reg  <= long_next;
    end
  end

  assign current_state = state_reg;
  assign short_counter = short_reg;
  assign long_counter  = long_reg;

endmodule

// File: tb/tb_traffic_lights.sv
// Randomised and directed checks of traffic_lights against a phase/road model.
module tb_traffic_lights;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:1] s1 = '0;
  logic [4:1] s5 = '0;
  logic       cd = 1'b0;
  logic       short_counter, long_counter;
  logic [3:0] current_state;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 green, 2 yellow; roads numbered 1..4.
  int m_phase = 0;
  int m_road  = 1;
  int m_last  = 4;
  int exp_state = 0;
  logic exp_short = 1'b0;
  logic exp_long  = 1'b0;

  traffic_lights dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sensor_1_1  (s1[1]),
    .i_sensor_2_1  (s1[2]),
    .i_sensor_3_1  (s1[3]),
    .i_sensor_4_1  (s1[4]),
    .i_sensor_1_5  (s5[1]),
    .i_sensor_2_5  (s5[2]),
    .i_sensor_3_5  (s5[3]),
    .i_sensor_4_5  (s5[4]),
    .counter_done  (cd),
    .short_counter (short_counter),
    .long_counter  (long_counter),
    .current_state (current_state)
  );

  always #5 clk = ~clk;

  function automatic int select_road(input int last);
    int r;
    for (int k = 1; k <= 4; k++) begin
      r = ((last - 1 + k) % 4) + 1;
      if (s1[r] || s5[r]) return r;
    end
    return 0;
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_road = 1; m_last = 4;
    exp_state = 0; exp_short = 1'b0; exp_long = 1'b0;
  endfunction

  function automatic void grant(input int r);
    m_phase = 1; m_road = r;
    exp_long = s5[r]; exp_short = !s5[r];
  endfunction

  // Advance one clock edge, update the model with the inputs seen at that edge.
  task automatic step();
    int r;
    @(posedge clk);
    exp_short = 1'b0; exp_long = 1'b0;
    if (m_phase == 0) begin
      r = select_road(m_last);
      if (r != 0) grant(r);
    end else if (m_phase == 1) begin
      if (cd) begin m_phase = 2; exp_short = 1'b1; end
    end else if (cd) begin
      m_last = m_road;
      r = select_road(m_road);
      if (r != 0) grant(r); else m_phase = 0;
    end
    exp_state = (m_phase == 0) ? 0 : (2 * m_road - 1 + (m_phase == 2 ? 1 : 0));
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s1 = '0; s5 = '0; cd = 1'b0;
    #12;
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", current_state); end
    checks++; if (short_counter !== 1'b0) begin errors++; $display("FAIL reset_short got=%b want=0", short_counter); end
    checks++; if (long_counter !== 1'b0) begin errors++; $display("FAIL reset_long got=%b want=0", long_counter); end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step();
    checks++; if (current_state !== 4'd0) begin errors++; $display("FAIL idle_no_req got=%0d want=0", current_state); end
    $display("test_reset: state=%0d", current_state);
  endtask

  task automatic test_first_grant();
    int bad = 0;
    s1 = 4'b0001; s5 = 4'b0001; cd = 1'b0;
    step();
    checks++; if (current_state !== 4'd1 || current_state !== exp_state[3:0]) begin errors++; $display("FAIL first_grant_state got=%0d want=1", current_state); end
    checks++; if (long_counter !== 1'b1 || short_counter !== 1'b0) begin errors++; $display("FAIL first_grant_pulse got=l%b s%b want=l1 s0", long_counter, short_counter); end
    for (int i = 0; i < 62; i++) begin
      step();
      if (current_state !== 4'd1 || long_counter !== 1'b0 || short_counter !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL green_hold got=%0d bad cycles want=0", bad); end
    $display("test_first_grant: state=%0d held 62 cycles", current_state);
  endtask

  task automatic test_yellow_then_long();
    cd = 1'b1;
    step();
    cd = 1'b0;
    checks++; if (current_state !== 4'd2 || short_counter !== 1'b1 || long_counter !== 1'b0) begin errors++; $display("FAIL yellow1 got=%0d s%b l%b want=2 s1 l0", current_state, short_counter, long_counter); end
    step();
    checks++; if (short_counter !== 1'b0 || current_state !== 4'd2) begin errors++; $display("FAIL yellow1_hold got=%0d s%b want=2 s0", current_state, short_counter); end
    s1[2] = 1'b1; s5[2] = 1'b1;
    cd = 1'b1;
    step();
    cd = 1'b0;
    checks++; if (current_state !== 4'd3 || long_counter !== 1'b1 || short_counter !== 1'b0) begin errors++; $display("FAIL green2_long got=%0d l%b s%b want=3 l1 s0", current_state, long_counter, short_counter); end
    $display("test_yellow_then_long: state=%0d", current_state);
  endtask

  task automatic test_all_sensors();
    int greens[$];
    int want[5] = '{1, 3, 5, 7, 1};
    int bad_long = 0;
    do_reset();
    s1 = 4'b1111; s5 = 4'b1111; cd = 1'b0;
    step();
    greens.push_back(current_state);
    if (long_counter !== 1'b1) bad_long++;
    cd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (current_state !== exp_state[3:0] || short_counter !== exp_short || long_counter !== exp_long) begin errors++; $display("FAIL all_sensors_step%0d got=%0d s%b l%b want=%0d s%b l%b", i, current_state, short_counter, long_counter, exp_state, exp_short, exp_long); end
      if (current_state[0]) begin
        greens.push_back(current_state);
        if (long_counter !== 1'b1) bad_long++;
      end
    end
    cd = 1'b0;
    checks++; if (greens.size() != 5) begin errors++; $display("FAIL green_count got=%0d want=5", greens.size()); end
    for (int i = 0; i < 5 && i < greens.size(); i++) begin
      checks++; if (greens[i] != want[i]) begin errors++; $display("FAIL green_order[%0d] got=%0d want=%0d", i, greens[i], want[i]); end
    end
    checks++; if (bad_long != 0) begin errors++; $display("FAIL green_long got=%0d misses want=0", bad_long); end
    $display("test_all_sensors: greens=%0d", greens.size());
  endtask

  task automatic test_short_only();
    int bad = 0;
    int entries = 0;
    s1 = 4'b1111; s5 = 4'b0000;
    for (int i = 0; i < 60; i++) begin
      cd = ($urandom_range(0, 2) == 0);
      step();
      if (long_counter !== 1'b0) bad++;
      if (current_state !== exp_state[3:0] || short_counter !== exp_short) bad++;
      if (short_counter && current_state[0]) entries++;
    end
    cd = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL short_only got=%0d bad cycles want=0", bad); end
    $display("test_short_only: green entries=%0d", entries);
  endtask

  task automatic test_idle();
    int n = 0;
    int bad = 0;
    s1 = '0; s5 = '0; cd = 1'b1;
    while (m_phase != 0 && n < 20) begin
      step();
      n++;
    end
    checks++; if (m_phase != 0) begin errors++; $display("FAIL idle_timeout got=phase%0d want=idle", m_phase); end
    checks++; if (current_state !== 4'd0 || short_counter !== 1'b0 || long_counter !== 1'b0) begin errors++; $display("FAIL enter_idle got=%0d s%b l%b want=0 s0 l0", current_state, short_counter, long_counter); end
    for (int i = 0; i < 10; i++) begin
      cd = i[0];
      step();
      if (current_state !== 4'd0 || short_counter !== 1'b0 || long_counter !== 1'b0) bad++;
    end
    cd = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_ignores_done got=%0d bad cycles want=0", bad); end
    $display("test_idle: reached idle after %0d cycles", n);
  endtask

  task automatic test_async_reset();
    do_reset();
    s1 = 4'b0100; s5 = 4'b0000; cd = 1'b0;
    step();
    checks++; if (current_state !== 4'd5 || short_counter !== 1'b1) begin errors++; $display("FAIL g3_entry got=%0d s%b want=5 s1", current_state, short_counter); end
    step(); step();
    s1 = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (current_state !== 4'd0 || short_counter !== 1'b0 || long_counter !== 1'b0) begin errors++; $display("FAIL async_reset got=%0d s%b l%b want=0 s0 l0", current_state, short_counter, long_counter); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (current_state !== 4'd1 || exp_state != 1) begin errors++; $display("FAIL restart_road1 got=%0d want=1", current_state); end
    $display("test_async_reset: restarted at state=%0d", current_state);
  endtask

  task automatic test_random();
    int bad = 0;
    s1 = '0; s5 = '0; cd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      s1 = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      s5 = s1 & 4'($urandom_range(0, 15));
      cd = ($urandom_range(0, 3) == 0);
      step();
      if (current_state !== exp_state[3:0] || short_counter !== exp_short || long_counter !== exp_long || (short_counter && long_counter)) begin
        bad++;
        if (bad <= 5) $display("FAIL random_cycle%0d got=%0d s%b l%b want=%0d s%b l%b", i, current_state, short_counter, long_counter, exp_state, exp_short, exp_long);
      end
    end
    cd = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL random_total got=%0d bad cycles want=0", bad); end
    $display("test_random: 400 cycles, mismatching cycles=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_yellow_then_long();
    test_all_sensors();
    test_short_only();
    test_idle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_lights.md
TRAFFIC_LIGHTS -- requirements
Module: traffic_lights

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 i_sensor_1_1, i_sensor_2_1, i_sensor_3_1, i_sensor_4_1  input  1 each  road N has at least one car waiting at the stop line.
REQ-005 i_sensor_1_5, i_sensor_2_5, i_sensor_3_5, i_sensor_4_5  input  1 each  road N queue has reached five or more cars.
REQ-006 counter_done  input  1  one-cycle pulse from the external phase timer: the current timed phase has expired.
REQ-007 short_counter  output  1  one-cycle start pulse: request a short timed phase.
REQ-008 long_counter  output  1  one-cycle start pulse: request a long timed phase.
REQ-009 current_state  output  4  registered FSM state code.

Function
REQ-010 State encoding SHALL be:
- 0 IDLE (all red)
- 1 G1, 2 Y1 (road 1 green, yellow)
- 3 G2, 4 Y2
- 5 G3, 6 Y3
- 7 G4, 8 Y4
- codes 9-15 unused.
REQ-011 Road N SHALL be "requesting" when i_sensor_N_1 or i_sensor_N_5 is 1.
REQ-012 Next-road selection SHALL scan cyclically, starting at the road after the last-served road, and pick the first requesting road.
- Last-served road after reset is 4, so road 1 is scanned first.
REQ-013 In IDLE, selection SHALL be evaluated every cycle.
- Requesting road found -> enter its G state on the next edge.
- Otherwise -> stay in IDLE.
REQ-014 In GN, the FSM SHALL hold until counter_done=1, then move to YN on the next edge.
- Sensor changes during GN are ignored.
REQ-015 In YN, the FSM SHALL hold until counter_done=1, then apply selection (road N becomes last-served).
- Requesting road found -> its G state.
- None -> IDLE.
- Road N itself is eligible again only if no other road is requesting.
REQ-016 On the edge that enters GN, long_counter SHALL be 1 for that cycle if i_sensor_N_5 was 1 at the decision edge, else short_counter SHALL be 1.
REQ-017 On the edge that enters any YN, short_counter SHALL be 1 for one cycle.
REQ-018 short_counter and long_counter SHALL be registered, are never both 1, and are 0 in every cycle without a state entry.
REQ-019 counter_done SHALL be ignored in IDLE.
REQ-020 counter_done held high for several cycles SHALL advance the FSM one state per cycle, with each entry issuing its pulse.
REQ-021 If the FSM reaches an unused code, it SHALL return to IDLE on the next edge with no pulse.
REQ-022 current_state SHALL change only on rising clk edges, outside reset.

Reset
REQ-023 While rst_n=0, the block SHALL hold current_state=0, short_counter=0, long_counter=0 and last-served road = 4, asynchronously.
REQ-024 On release of rst_n, the first rising edge SHALL perform IDLE evaluation per REQ-013.
REQ-025 Reset asserted mid-phase SHALL abort the phase immediately, with no pulses issued.

Verification
REQ-026 Reset, then sensor_1_1=sensor_1_5=1, road 2 sensors 0 -> next edge current_state=1, long_counter=1 for one cycle; state stays 1 for 62 cycles while counter_done=0.
REQ-027 From G1, pulse counter_done -> state 2, short_counter pulse; next counter_done with road 2 sensors 1/1 -> state 3, long_counter pulse.
REQ-028 All eight sensors 1, four green/yellow cycles -> green order is 1,3,5,7 then back to 1, each green entry with long_counter=1.
REQ-029 All *_5 sensors 0 and all *_1 sensors 1 -> every green entry issues short_counter only; long_counter stays 0.
REQ-030 All sensors 0 at a yellow-phase counter_done -> state 0 with no pulse; counter_done pulses in IDLE leave state 0.
REQ-031 Assert rst_n=0 while in G3 between clock edges -> current_state=0 immediately with outputs 0; after release, scan restarts at road 1.
